// File: rtl/ltt_pkg.sv
// Shared types and default sizing for the ltt_sequencer block.
// Holds the FSM state enum and the default operand width / threshold.
package ltt_pkg;

    localparam int unsigned DefaultW      = 4;
    localparam int unsigned DefaultThresh = 2;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StResp
    } state_e;

endpackage

// File: rtl/below_thresh.sv
// Unsigned "value < THRESH" comparator, shared by the accept and count stages.
module below_thresh
    import ltt_pkg::*;
#(
    parameter int unsigned W      = DefaultW,
    parameter int unsigned THRESH = DefaultThresh
) (
    input  logic [W-1:0] value,
    output logic         below
);

    // Compare at 32 bits so THRESH may exceed the operand range.
    assign below = (32'(value) < THRESH);

endmodule

// File: rtl/ltt_sequencer.sv
// Two-requester round-robin sequencer: counts an operand down to THRESH and
// returns the number of decrements plus a ">= THRESH" flag.
module ltt_sequencer
    import ltt_pkg::*;
#(
    parameter int unsigned W      = DefaultW,
    parameter int unsigned THRESH = DefaultThresh
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [W-1:0] res_steps,
    output logic         res_ge,
    output logic         busy
);

    // THRESH of zero means every operand is already done on arrival.
    localparam bit NoThresh = (THRESH == 0);

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] steps_q, steps_d;
    logic         id_q, id_d;
    logic         ge_q, ge_d;
    logic         rr_q, rr_d;

    logic         grant_any;
    logic         grant;
    logic [W-1:0] cmp_value;
    logic         below;
    logic         count_done;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = rr_q;
        end else begin
            grant = req1_valid;
        end
    end

    // One comparator: granted operand while idle, running count otherwise.
    assign cmp_value  = (state_q == StIdle) ? (grant ? req1_data : req0_data) : cnt_q;
    assign count_done = below | NoThresh;

    below_thresh #(
        .W      (W),
        .THRESH (THRESH)
    ) u_below (
        .value (cmp_value),
        .below (below)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        steps_d    = steps_q;
        id_d       = id_q;
        ge_d       = ge_q;
        rr_d       = rr_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    cnt_d      = cmp_value;
                    steps_d    = '0;
                    id_d       = grant;
                    ge_d       = ~below;
                    state_d    = StCount;
                end
            end
            StCount: begin
                if (count_done) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = cnt_q - W'(1);
                    steps_d = steps_q + W'(1);
                end
            end
            StResp: begin
                if (res_ready) begin
                    rr_d    = ~id_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            steps_q <= '0;
            id_q    <= 1'b0;
            ge_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            steps_q <= steps_d;
            id_q    <= id_d;
            ge_q    <= ge_d;
            rr_q    <= rr_d;
        end
    end

    assign res_valid = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign res_id    = id_q;
    assign res_steps = steps_q;
    assign res_ge    = ge_q;

endmodule

// File: tb/tb_ltt_sequencer.sv
// Directed self-checking bench for ltt_sequencer (THRESH=2 main instance,
// plus a THRESH=0 instance for the degenerate threshold).
module tb_ltt_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req0_valid;
    logic [3:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_data;
    logic       req1_ready;
    logic       res_valid;
    logic       res_ready;
    logic       res_id;
    logic [3:0] res_steps;
    logic       res_ge;
    logic       busy;

    logic       z_valid;
    logic [3:0] z_data;
    logic       z_ready;
    logic       z_req1_valid;
    logic [3:0] z_req1_data;
    logic       z_req1_ready;
    logic       z_res_valid;
    logic       z_res_ready;
    logic       z_res_id;
    logic [3:0] z_res_steps;
    logic       z_res_ge;
    logic       z_busy;

    int checks = 0;
    int errors = 0;

    ltt_sequencer #(
        .W      (4),
        .THRESH (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_steps  (res_steps),
        .res_ge     (res_ge),
        .busy       (busy)
    );

    ltt_sequencer #(
        .W      (4),
        .THRESH (0)
    ) u_dut_t0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (z_valid),
        .req0_data  (z_data),
        .req0_ready (z_ready),
        .req1_valid (z_req1_valid),
        .req1_data  (z_req1_data),
        .req1_ready (z_req1_ready),
        .res_valid  (z_res_valid),
        .res_ready  (z_res_ready),
        .res_id     (z_res_id),
        .res_steps  (z_res_steps),
        .res_ge     (z_res_ge),
        .busy       (z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_id"}, 32'(res_id), 0);
        check({tag, "_res_steps"}, 32'(res_steps), 0);
        check({tag, "_res_ge"}, 32'(res_ge), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ready0"}, 32'(req0_ready), 0);
        check({tag, "_ready1"}, 32'(req1_ready), 0);
    endtask

    // Called #1 after a negedge with request(s) driven; returns at the
    // negedge where res_valid is first seen high.
    task automatic wait_result(input int exp_id, input int exp_steps, input logic exp_ge,
                               input bit drop, input string tag);
        int k;
        check({tag, "_ready_own"}, 32'(exp_id == 0 ? req0_ready : req1_ready), 1);
        check({tag, "_ready_other"}, 32'(exp_id == 0 ? req1_ready : req0_ready), 0);
        @(negedge clk);
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        k = 1;
        check({tag, "_busy_count"}, 32'(busy), 1);
        check({tag, "_ready_count"}, 32'({req0_ready, req1_ready}), 0);
        while (!res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(2 + exp_steps));
        check({tag, "_id"}, 32'(res_id), 32'(exp_id));
        check({tag, "_steps"}, 32'(res_steps), 32'(exp_steps));
        check({tag, "_ge"}, 32'(res_ge), 32'(exp_ge));
    endtask

    task automatic serve(input int who, input logic [3:0] d, input int exp_steps,
                         input logic exp_ge, input string tag);
        @(negedge clk);
        if (who == 0) begin
            req0_valid = 1'b1;
            req0_data  = d;
        end else begin
            req1_valid = 1'b1;
            req1_data  = d;
        end
        #1;
        wait_result(who, exp_steps, exp_ge, 1'b1, tag);
    endtask

    initial begin
        int k;
        int bad;
        logic [3:0] d;
        logic [3:0] zv [3];

        rst_n        = 1'b0;
        req0_valid   = 1'b0;
        req0_data    = '0;
        req1_valid   = 1'b0;
        req1_data    = '0;
        res_ready    = 1'b1;
        z_valid      = 1'b0;
        z_data       = '0;
        z_req1_valid = 1'b0;
        z_req1_data  = '0;
        z_res_ready  = 1'b1;

        repeat (3) @(negedge clk);
        check_reset("reset");

        // Release reset and request on the same cycle: accept at first edge.
        @(negedge clk);
        rst_n      = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 4'd9;
        #1;
        wait_result(0, 8, 1'b1, 1'b1, "d9");

        serve(1, 4'd1, 0, 1'b0, "r1_d1");
        serve(1, 4'd0, 0, 1'b0, "r1_d0");

        // Both held valid from reset: alternation starting with requester 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 4'd3;
        req1_valid = 1'b1;
        req1_data  = 4'd5;
        #1;
        wait_result(0, 2, 1'b1, 1'b0, "alt0");
        @(negedge clk);
        #1;
        wait_result(1, 4, 1'b1, 1'b0, "alt1");
        @(negedge clk);
        #1;
        wait_result(0, 2, 1'b1, 1'b0, "alt2");
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-pressure in RESP with both requesters asking.
        @(negedge clk);
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 4'd15;
        #1;
        wait_result(0, 14, 1'b1, 1'b0, "bp");
        req1_valid = 1'b1;
        req1_data  = 4'd4;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!res_valid || res_steps !== 4'd14 || res_id !== 1'b0 || res_ge !== 1'b1 ||
                req0_ready || req1_ready) begin
                bad++;
            end
        end
        check("bp_hold", 32'(bad), 0);
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_idle_busy", 32'(busy), 0);
        check("bp_rr_ready1", 32'(req1_ready), 1);
        check("bp_rr_ready0", 32'(req0_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset asserted mid-count abandons the operation.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 4'd12;
        #1;
        check("rst_mid_ready", 32'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid || busy) bad++;
        end
        check("rst_mid_quiet", 32'(bad), 0);

        // Full operand sweep on requester 0.
        for (int i = 0; i < 16; i++) begin
            d = i[3:0];
            serve(0, d, (i >= 2) ? i - 1 : 0, (i >= 2) ? 1'b1 : 1'b0, $sformatf("sweep%0d", i));
        end

        // THRESH=0 instance: zero steps and ge=1 for any operand.
        zv[0] = 4'd0;
        zv[1] = 4'd7;
        zv[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            z_valid = 1'b1;
            z_data  = zv[i];
            #1;
            check($sformatf("t0_%0d_ready", i), 32'(z_ready), 1);
            @(negedge clk);
            z_valid = 1'b0;
            k = 1;
            while (!z_res_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("t0_%0d_latency", i), 32'(k), 2);
            check($sformatf("t0_%0d_steps", i), 32'(z_res_steps), 0);
            check($sformatf("t0_%0d_ge", i), 32'(z_res_ge), 1);
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltt_sequencer.md
LTT_SEQUENCER -- requirements
Module: ltt_sequencer

Interface
REQ-001 Parameter W, default 4, SHALL set the operand width in bits.
REQ-002 Parameter THRESH, default 2, SHALL set the unsigned "below threshold" limit (value < THRESH).
REQ-003 clk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req0_valid  in  1  SHALL indicate requester 0 presents an operand.
REQ-006 req0_data  in  W  SHALL carry requester 0 operand (unsigned).
REQ-007 req0_ready  out  1  SHALL indicate requester 0 operand accepted this cycle.
REQ-008 req1_valid / req1_data / req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 res_valid  out  1  SHALL indicate a result is presented.
REQ-010 res_ready  in  1  SHALL indicate the consumer takes the result.
REQ-011 res_id  out  1  SHALL identify the served requester (0/1).
REQ-012 res_steps  out  W  SHALL give the number of decrements performed.
REQ-013 res_ge  out  1  SHALL be 1 when the accepted operand was >= THRESH.
REQ-014 busy  out  1  SHALL be 1 whenever state is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, COUNT, RESP.
REQ-016 IDLE: if exactly one valid, grant it; if both valid, grant the requester not served last (rr pointer).
REQ-017 reqN_ready SHALL be combinational, asserted only in IDLE for the granted requester, never both.
REQ-018 On accept: cnt <= data, steps <= 0, id <= granted, ge <= (data >= THRESH); next state COUNT.
REQ-019 COUNT: if cnt < THRESH, go RESP; else cnt <= cnt-1, steps <= steps+1, stay COUNT.
REQ-020 Decrement SHALL never wrap: cnt >= THRESH >= 1 whenever decremented; steps SHALL never exceed 2^W-1.
REQ-021 Result: steps = max(0, data-THRESH+1); for THRESH=2: data 0 -> 0, 1 -> 0, 2 -> 1, 15 -> 14.
REQ-022 Latency: accept at cycle N -> res_valid first high at cycle N+2+steps.
REQ-023 RESP: res_valid=1, res_id/res_steps/res_ge stable until res_valid&&res_ready.
REQ-024 On result handshake: rr pointer <= ~id, next state IDLE; no accept in that same cycle.
REQ-025 Requests arriving outside IDLE SHALL be held off (ready=0); requester data not sampled.
REQ-026 THRESH=0 SHALL yield steps 0 and ge=1 for every operand.

Reset
REQ-027 rst_n low SHALL force IDLE, rr pointer favouring requester 0, cnt=0, steps=0, id=0, ge=0.
REQ-028 Reset outputs: res_valid=0, res_id=0, res_steps=0, res_ge=0, busy=0, req0_ready=0, req1_ready=0.
REQ-029 Reset asserted mid-COUNT or mid-RESP SHALL abandon the operation; no result emitted afterward.
REQ-030 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package ltt_pkg SHALL hold the state enum (IDLE, COUNT, RESP) and default W/THRESH constants.
REQ-032 One sub-module, below_thresh (combinational: out = in < THRESH), SHALL be instantiated once and shared by IDLE (ge) and COUNT (exit test).
REQ-033 Block SHALL contain no memories, no latches, a single clock domain.

Verification
REQ-034 req0 data=9 alone, res_ready=1 -> res_valid at accept+10, res_id=0, res_steps=8, res_ge=1.
REQ-035 req1 data=1 -> res_steps=0, res_ge=0, res_valid at accept+2; data=0 identical.
REQ-036 Both valid from reset, data 3/5, res_ready=1 -> req0 served first (steps 2), then req1 (steps 4); both held valid -> strict alternation.
REQ-037 data=15, res_ready low 5 cycles in RESP -> outputs stable, ready deasserted on both requesters, res_steps=14 on handshake.
REQ-038 rst_n pulsed low during COUNT with data=12 -> all outputs at reset values immediately; no res_valid until new request.
REQ-039 THRESH=2 sweep data 0..15 -> res_ge equals (data>=2), res_steps equals max(0,data-1).
